// File: rtl/wave_capture_buffer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : wave_capture_buffer_pkg                                  |
// | Purpose  : Shared audio/display definitions for the capture path:   |
// |            capture FSM state encoding, sample/display widths and    |
// |            the signed-sample to display-byte conversion.            |
// | Ports    : none (package)                                          |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package wave_capture_buffer_pkg;

   localparam int SAMPLE_W = 16;
   localparam int DISP_W   = 8;

   typedef enum logic [1:0] {
      ARMED  = 2'd0,
      ACTIVE = 2'd1,
      WAIT   = 2'd2
   } capture_state_t;

   // Top byte of the signed sample offset by 128: flipping the sign bit
   // turns two's-complement into offset-binary, so -32768 -> 0x00,
   // 0 -> 0x80, 32767 -> 0xFF.
   function automatic logic [DISP_W-1:0] to_display(input logic [SAMPLE_W-1:0] s);
      return {~s[SAMPLE_W-1], s[SAMPLE_W-2:SAMPLE_W-DISP_W]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/wave_capture_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : wave_capture_buffer_if                                   |
// | Purpose  : Sample stream in, sample-RAM write port and buffer       |
// |            select out, for the wave capture stage.                  |
// | Ports    : new_sample_ready/new_sample_in  - audio sample strobe    |
// |            wave_display_idle               - safe-to-swap flag      |
// |            write_address/enable/sample     - RAM write port         |
// |            read_index                      - half the display reads |
// |            slave modport  : capture block side                      |
// |            master modport : sample source / RAM / display side      |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
interface wave_capture_buffer_if #(
   parameter int ADDR_BITS = 8
);
   import wave_capture_buffer_pkg::*;

   logic                 new_sample_ready;
   logic [SAMPLE_W-1:0]  new_sample_in;
   logic                 wave_display_idle;
   logic [ADDR_BITS:0]   write_address;
   logic                 write_enable;
   logic [DISP_W-1:0]    write_sample;
   logic                 read_index;

   modport slave (
      input  new_sample_ready,
      input  new_sample_in,
      input  wave_display_idle,
      output write_address,
      output write_enable,
      output write_sample,
      output read_index
   );

   modport master (
      output new_sample_ready,
      output new_sample_in,
      output wave_display_idle,
      input  write_address,
      input  write_enable,
      input  write_sample,
      input  read_index
   );

endinterface
`default_nettype wire

// File: rtl/wave_capture_buffer_zero_cross_detect.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : zero_cross_detect                                        |
// | Purpose  : Remembers the sign of the last accepted sample and       |
// |            flags a negative-to-non-negative transition.             |
// | Ports    : clk, reset     - clock, async active-high reset          |
// |            sample_valid   - a sample is accepted this cycle         |
// |            sample_msb     - sign bit of that sample                 |
// |            clear          - forget history (re-arm)                 |
// |            trigger        - combinational positive-going crossing   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module zero_cross_detect (
   input  wire logic clk,
   input  wire logic reset,
   input  wire logic sample_valid,
   input  wire logic sample_msb,
   input  wire logic clear,
   output logic      trigger
);

   logic r_prev_msb;
   logic r_prev_valid;

   // Without valid history a stale negative sign could fire a bogus
   // trigger on the first sample after re-arm, hence the qualifier.
   assign trigger = sample_valid & r_prev_valid & r_prev_msb & ~sample_msb;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prev_msb   <= 1'b0;
         r_prev_valid <= 1'b0;
      end else if (clear) begin
         r_prev_valid <= 1'b0;
      end else if (sample_valid) begin
         r_prev_msb   <= sample_msb;
         r_prev_valid <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/wave_capture_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : wave_capture_buffer                                      |
// | Purpose  : Waits for a positive-going zero crossing, then writes    |
// |            the next 2^ADDR_BITS samples (as display bytes) into the |
// |            RAM half the display is not reading, and flips the       |
// |            display to it once the display is idle.                  |
// | Ports    : clk   - system clock                                     |
// |            reset - asynchronous active-high reset                   |
// |            bus   - wave_capture_buffer_if.slave (samples in, RAM    |
// |                    write port and read_index out)                   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module wave_capture_buffer
   import wave_capture_buffer_pkg::*;
#(
   parameter int ADDR_BITS = 8
) (
   input  wire logic               clk,
   input  wire logic               reset,
   wave_capture_buffer_if.slave    bus
);

   localparam logic [ADDR_BITS-1:0] c_last_index = '1;

   capture_state_t        r_state;
   logic [ADDR_BITS-1:0]  r_count;
   logic                  r_read_index;
   logic                  r_write_enable;
   logic [ADDR_BITS:0]    r_write_address;
   logic [DISP_W-1:0]     r_write_sample;

   logic                  w_sample_accept;
   logic                  w_rearm;
   logic                  w_trigger;

   // Samples arriving in WAIT are dropped entirely, including for the
   // crossing history; the re-arm cycle is itself a WAIT cycle.
   assign w_sample_accept = bus.new_sample_ready && (r_state != WAIT);
   assign w_rearm         = (r_state == WAIT) && bus.wave_display_idle;

   zero_cross_detect u_zero_cross_detect (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (w_sample_accept),
      .sample_msb   (bus.new_sample_in[SAMPLE_W-1]),
      .clear        (w_rearm),
      .trigger      (w_trigger)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= ARMED;
         r_count         <= '0;
         r_read_index    <= 1'b0;
         r_write_enable  <= 1'b0;
         r_write_address <= '0;
         r_write_sample  <= '0;
      end else begin
         r_write_enable <= 1'b0;
         case (r_state)
            ARMED: begin
               // The triggering sample is not stored.
               if (w_trigger) begin
                  r_state <= ACTIVE;
                  r_count <= '0;
               end
            end
            ACTIVE: begin
               if (bus.new_sample_ready) begin
                  r_write_enable  <= 1'b1;
                  r_write_address <= {~r_read_index, r_count};
                  r_write_sample  <= to_display(bus.new_sample_in);
                  r_count         <= r_count + 1'b1;
                  if (r_count == c_last_index) begin
                     r_state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (bus.wave_display_idle) begin
                  r_read_index <= ~r_read_index;
                  r_state      <= ARMED;
               end
            end
            default: r_state <= ARMED;
         endcase
      end
   end

   assign bus.write_enable  = r_write_enable;
   assign bus.write_address = r_write_address;
   assign bus.write_sample  = r_write_sample;
   assign bus.read_index    = r_read_index;

endmodule
`default_nettype wire

// File: tb/tb_wave_capture_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_wave_capture_buffer                                   |
// | Purpose  : Directed self-checking bench for wave_capture_buffer.    |
// | Ports    : none                                                     |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_wave_capture_buffer;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   wave_capture_buffer_if #(.ADDR_BITS(8)) bus();

   wave_capture_buffer #(.ADDR_BITS(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One-cycle sample strobe with 2 idle cycles before it; returns on
   // the falling edge just after the capturing rising edge.
   task automatic send(input logic [15:0] s);
      repeat (2) @(negedge clk);
      bus.new_sample_ready = 1'b1;
      bus.new_sample_in    = s;
      @(negedge clk);
      bus.new_sample_ready = 1'b0;
   endtask

   task automatic send_nowrite(input string tag, input logic [15:0] s);
      send(s);
      chk(tag, {15'd0, bus.write_enable}, 16'd0);
   endtask

   task automatic send_write(input string tag, input logic [15:0] s,
                             input logic [8:0] addr, input logic [7:0] data);
      send(s);
      chk({tag, "_we"},   {15'd0, bus.write_enable}, 16'd1);
      chk({tag, "_addr"}, {7'd0, bus.write_address}, {7'd0, addr});
      chk({tag, "_data"}, {8'd0, bus.write_sample},  {8'd0, data});
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      bus.new_sample_ready  = 1'b0;
      bus.new_sample_in     = 16'h0000;
      bus.wave_display_idle = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_we",   {15'd0, bus.write_enable}, 16'd0);
      chk("rst_addr", {7'd0, bus.write_address}, 16'd0);
      chk("rst_data", {8'd0, bus.write_sample},  16'd0);
      chk("rst_ri",   {15'd0, bus.read_index},   16'd0);
      reset = 1'b0;

      // Trigger on -1 -> 0, then conversion of the first captured samples
      send_nowrite("t1_m100", 16'hFF9C);
      send_nowrite("t1_m1",   16'hFFFF);
      send_nowrite("t1_zero", 16'h0000);
      send_write("t1_s0", 16'h1234, 9'h100, 8'h92);
      @(negedge clk);
      chk("t1_we_pulse", {15'd0, bus.write_enable}, 16'd0);
      send_write("t1_s1", 16'h7FFF, 9'h101, 8'hFF);
      send_write("t1_s2", 16'h8000, 9'h102, 8'h00);

      // Rest of the capture; last sample negative for the stale-sign test
      for (int k = 3; k < 255; k++) begin
         logic [7:0] kb;
         kb = k[7:0];
         send_write("t3_fill", {kb, 8'h00}, {1'b1, kb}, kb ^ 8'h80);
      end
      send_write("t3_last", 16'hFB00, 9'h1FF, 8'h7B);

      // WAIT: samples ignored, idle low holds the swap
      send_nowrite("t3_wait_ign", 16'h4000);
      repeat (20) @(negedge clk);
      chk("t3_ri_hold", {15'd0, bus.read_index}, 16'd0);
      bus.wave_display_idle = 1'b1;
      @(negedge clk);
      chk("t3_ri_flip", {15'd0, bus.read_index}, 16'd1);
      bus.wave_display_idle = 1'b0;

      // Re-arm: 10 must not trigger despite the negative last sample
      send_nowrite("t5_10", 16'd10);
      send_nowrite("t2_0",  16'd0);
      send_nowrite("t2_5",  16'd5);
      send_nowrite("t2_9",  16'd9);
      send_nowrite("t2_m3", 16'hFFFD);
      send_nowrite("t2_7",  16'd7);

      // Capture into half 0 up to count 100, then async reset
      for (int k = 0; k < 100; k++) begin
         logic [7:0] kb;
         kb = k[7:0];
         send_write("t6_pre", {kb, 8'h00}, {1'b0, kb}, kb ^ 8'h80);
      end
      #2 reset = 1'b1;
      #1;
      chk("t6_we_async",   {15'd0, bus.write_enable}, 16'd0);
      chk("t6_ri_async",   {15'd0, bus.read_index},   16'd0);
      chk("t6_addr_async", {7'd0, bus.write_address}, 16'd0);
      @(negedge clk);
      reset = 1'b0;

      // Fresh trigger after reset; idle high outside WAIT has no effect
      bus.wave_display_idle = 1'b1;
      send_nowrite("t6_m1",   16'hFFFF);
      send_nowrite("t6_zero", 16'h0000);
      chk("t6_ri_idle_armed", {15'd0, bus.read_index}, 16'd0);

      // Back-to-back capture of 256 samples
      @(negedge clk);
      for (int i = 0; i < 256; i++) begin
         logic [7:0] ib;
         ib = i[7:0];
         bus.new_sample_ready = 1'b1;
         bus.new_sample_in    = {ib, 8'h00};
         @(negedge clk);
         chk("t4_we",   {15'd0, bus.write_enable}, 16'd1);
         chk("t4_addr", {7'd0, bus.write_address}, {7'd0, 1'b1, ib});
         chk("t4_data", {8'd0, bus.write_sample},  {8'd0, ib ^ 8'h80});
      end
      bus.new_sample_ready = 1'b0;
      chk("t4_ri_entry", {15'd0, bus.read_index}, 16'd0);
      @(negedge clk);
      chk("t4_we_end", {15'd0, bus.write_enable}, 16'd0);
      chk("t4_ri_flip", {15'd0, bus.read_index}, 16'd1);
      bus.wave_display_idle = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
